// File: rtl/regfile_scoreboard_if.sv
// Bundles the write-back, operand-read and issue-handshake signals of regfile_scoreboard.
// master = decode/execute side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic            i_wb_rd_wvalid;
    logic [4:0]      i_wb_rd_waddr;
    logic [XLEN-1:0] i_wb_rd_wdata;
    logic [4:0]      i_rs1_raddr;
    logic [4:0]      i_rs2_raddr;
    logic [XLEN-1:0] o_rs1_rdata;
    logic [XLEN-1:0] o_rs2_rdata;
    logic            i_issue_valid;
    logic            i_issue_rs1_en;
    logic            i_issue_rs2_en;
    logic            i_issue_rd_en;
    logic [4:0]      i_issue_rd;
    logic            o_issue_ready;
    logic [5:0]      o_inflight;
    logic            o_wb_err;

    modport master (
        output i_wb_rd_wvalid, i_wb_rd_waddr, i_wb_rd_wdata,
        output i_rs1_raddr, i_rs2_raddr,
        output i_issue_valid, i_issue_rs1_en, i_issue_rs2_en, i_issue_rd_en, i_issue_rd,
        input  o_rs1_rdata, o_rs2_rdata, o_issue_ready, o_inflight, o_wb_err
    );

    modport slave (
        input  i_wb_rd_wvalid, i_wb_rd_waddr, i_wb_rd_wdata,
        input  i_rs1_raddr, i_rs2_raddr,
        input  i_issue_valid, i_issue_rs1_en, i_issue_rs2_en, i_issue_rd_en, i_issue_rd,
        output o_rs1_rdata, o_rs2_rdata, o_issue_ready, o_inflight, o_wb_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rv32i architectural register file (x1-x31) with a per-register busy scoreboard for issue hazards.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and clears to reads and issue.
module regfile_scoreboard #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);

    logic [XLEN-1:0] regs [1:31];
    logic [31:1]     busy;
    logic [31:1]     clear_vec;
    logic [31:1]     set_vec;
    logic [31:0]     busy_full;
    logic [31:0]     busy_eff;
    logic [5:0]      inflight;
    logic            wb_err;
    logic            wb_hit;
    logic            set_hit;
    logic            set_real;
    logic            clr_real;
    logic            issue_ready;
    logic            issue_fire;

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        logic [XLEN-1:0] value;
        if (addr == 5'd0) begin
            value = '0;
        end else begin
            value = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (wb_hit && (bus.i_wb_rd_waddr == addr)) begin
                value = bus.i_wb_rd_wdata;
            end
`endif
        end
        return value;
    endfunction

    always_comb begin
        wb_hit    = bus.i_wb_rd_wvalid && (bus.i_wb_rd_waddr != 5'd0);
        clear_vec = '0;
        if (wb_hit) begin
            clear_vec[bus.i_wb_rd_waddr] = 1'b1;
        end
        busy_full = {busy, 1'b0};
`ifdef REGFILE_BYPASS_EN
        busy_eff  = {busy & ~clear_vec, 1'b0};
`else
        busy_eff  = busy_full;
`endif
        issue_ready = !(bus.i_issue_rs1_en && busy_eff[bus.i_rs1_raddr])
                   && !(bus.i_issue_rs2_en && busy_eff[bus.i_rs2_raddr])
                   && !(bus.i_issue_rd_en  && busy_eff[bus.i_issue_rd]);
        issue_fire = bus.i_issue_valid && issue_ready;
        set_hit    = issue_fire && bus.i_issue_rd_en && (bus.i_issue_rd != 5'd0);
        set_vec    = '0;
        if (set_hit) begin
            set_vec[bus.i_issue_rd] = 1'b1;
        end
        // Count only real popcount changes: a set on an already-busy register or a
        // clear that the same-edge set overrides leaves the count untouched.
        set_real = set_hit && !busy_full[bus.i_issue_rd];
        clr_real = wb_hit && busy_full[bus.i_wb_rd_waddr]
                && !(set_hit && (bus.i_issue_rd == bus.i_wb_rd_waddr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[bus.i_wb_rd_waddr] <= bus.i_wb_rd_wdata;
        end
    end

    // Set has priority over clear so a same-edge reissue keeps the register busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            inflight <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy   <= (busy & ~clear_vec) | set_vec;
            wb_err <= wb_hit && !busy_full[bus.i_wb_rd_waddr];
            case ({set_real, clr_real})
                2'b10:   inflight <= inflight + 6'd1;
                2'b01:   inflight <= inflight - 6'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    assign bus.o_rs1_rdata   = read_port(bus.i_rs1_raddr);
    assign bus.o_rs2_rdata   = read_port(bus.i_rs2_raddr);
    assign bus.o_issue_ready = issue_ready;
    assign bus.o_inflight    = inflight;
    assign bus.o_wb_err      = wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow the REGFILE_BYPASS_EN setting.
module tb_regfile_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_scoreboard_if #(.XLEN(32)) rif ();

    regfile_scoreboard #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rif.i_wb_rd_wvalid = 1'b0;
        rif.i_wb_rd_waddr  = 5'd0;
        rif.i_wb_rd_wdata  = 32'd0;
        rif.i_rs1_raddr    = 5'd0;
        rif.i_rs2_raddr    = 5'd0;
        rif.i_issue_valid  = 1'b0;
        rif.i_issue_rs1_en = 1'b0;
        rif.i_issue_rs2_en = 1'b0;
        rif.i_issue_rd_en  = 1'b0;
        rif.i_issue_rd     = 5'd0;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        rif.i_issue_valid  = 1'b1;
        rif.i_issue_rs1_en = 1'b0;
        rif.i_issue_rs2_en = 1'b0;
        rif.i_issue_rd_en  = 1'b1;
        rif.i_issue_rd     = rd;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // Reset state
        rif.i_rs1_raddr    = 5'd5;
        rif.i_rs2_raddr    = 5'd0;
        rif.i_issue_valid  = 1'b0;
        rif.i_issue_rs1_en = 1'b1;
        rif.i_issue_rs2_en = 1'b1;
        rif.i_issue_rd_en  = 1'b1;
        rif.i_issue_rd     = 5'd5;
        #1;
        check("reset_rd_x5", rif.o_rs1_rdata, 32'd0);
        check("reset_rd_x0", rif.o_rs2_rdata, 32'd0);
        check("reset_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        check("reset_inflight", {26'd0, rif.o_inflight}, 32'd0);
        check("reset_wb_err", {31'd0, rif.o_wb_err}, 32'd0);
        idle_inputs();

        // Write to x0 is dropped silently
        rif.i_wb_rd_wvalid = 1'b1;
        rif.i_wb_rd_waddr  = 5'd0;
        rif.i_wb_rd_wdata  = 32'hDEADBEEF;
        tick();
        rif.i_wb_rd_wvalid = 1'b0;
        rif.i_rs1_raddr    = 5'd0;
        #1;
        check("x0_read", rif.o_rs1_rdata, 32'd0);
        check("x0_wb_err", {31'd0, rif.o_wb_err}, 32'd0);
        check("x0_inflight", {26'd0, rif.o_inflight}, 32'd0);

        // RAW stall on x3
        issue_rd(5'd3);
        #1;
        check("raw_first_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        tick();
        rif.i_issue_rd_en  = 1'b0;
        rif.i_issue_rs1_en = 1'b1;
        rif.i_rs1_raddr    = 5'd3;
        #1;
        check("raw_stall_ready", {31'd0, rif.o_issue_ready}, 32'd0);
        check("raw_inflight", {26'd0, rif.o_inflight}, 32'd1);
        rif.i_wb_rd_wvalid = 1'b1;
        rif.i_wb_rd_waddr  = 5'd3;
        rif.i_wb_rd_wdata  = 32'h12345678;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw_wb_cycle_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        check("raw_wb_cycle_data", rif.o_rs1_rdata, 32'h12345678);
`else
        check("raw_wb_cycle_ready", {31'd0, rif.o_issue_ready}, 32'd0);
        check("raw_wb_cycle_data", rif.o_rs1_rdata, 32'd0);
`endif
        tick();
        rif.i_wb_rd_wvalid = 1'b0;
        #1;
        check("raw_after_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        check("raw_after_data", rif.o_rs1_rdata, 32'h12345678);
        check("raw_after_inflight", {26'd0, rif.o_inflight}, 32'd0);
        check("raw_after_wb_err", {31'd0, rif.o_wb_err}, 32'd0);
        idle_inputs();

        // WAW stall on x7: inflight 1 -> 0 -> 1
        issue_rd(5'd7);
        tick();
        check("waw_inflight_1", {26'd0, rif.o_inflight}, 32'd1);
        check("waw_hold_ready", {31'd0, rif.o_issue_ready}, 32'd0);
        tick();
        check("waw_still_held", {31'd0, rif.o_issue_ready}, 32'd0);
        check("waw_hold_inflight", {26'd0, rif.o_inflight}, 32'd1);
        rif.i_issue_valid  = 1'b0;
        rif.i_wb_rd_wvalid = 1'b1;
        rif.i_wb_rd_waddr  = 5'd7;
        rif.i_wb_rd_wdata  = 32'h00000077;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("waw_wb_cycle_ready", {31'd0, rif.o_issue_ready}, 32'd1);
`else
        check("waw_wb_cycle_ready", {31'd0, rif.o_issue_ready}, 32'd0);
`endif
        tick();
        rif.i_wb_rd_wvalid = 1'b0;
        #1;
        check("waw_inflight_0", {26'd0, rif.o_inflight}, 32'd0);
        rif.i_issue_valid = 1'b1;
        #1;
        check("waw_reissue_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        tick();
        rif.i_issue_valid = 1'b0;
        check("waw_inflight_again", {26'd0, rif.o_inflight}, 32'd1);
        rif.i_wb_rd_wvalid = 1'b1;
        rif.i_wb_rd_waddr  = 5'd7;
        rif.i_wb_rd_wdata  = 32'h00000777;
        tick();
        rif.i_wb_rd_wvalid = 1'b0;
        check("waw_drain_inflight", {26'd0, rif.o_inflight}, 32'd0);
        check("waw_drain_wb_err", {31'd0, rif.o_wb_err}, 32'd0);
        idle_inputs();

        // Spurious write-back to non-busy x9
        rif.i_wb_rd_wvalid = 1'b1;
        rif.i_wb_rd_waddr  = 5'd9;
        rif.i_wb_rd_wdata  = 32'hA5A5A5A5;
        tick();
        rif.i_wb_rd_wvalid = 1'b0;
        rif.i_rs2_raddr    = 5'd9;
        #1;
        check("spurious_err_pulse", {31'd0, rif.o_wb_err}, 32'd1);
        check("spurious_data", rif.o_rs2_rdata, 32'hA5A5A5A5);
        check("spurious_inflight", {26'd0, rif.o_inflight}, 32'd0);
        tick();
        check("spurious_err_clear", {31'd0, rif.o_wb_err}, 32'd0);

        // Async reset mid-stream with x1, x2, x4 busy
        issue_rd(5'd1);
        tick();
        issue_rd(5'd2);
        tick();
        issue_rd(5'd4);
        tick();
        rif.i_issue_valid  = 1'b0;
        rif.i_issue_rs1_en = 1'b1;
        rif.i_issue_rs2_en = 1'b1;
        rif.i_issue_rd_en  = 1'b1;
        rif.i_rs1_raddr    = 5'd2;
        rif.i_rs2_raddr    = 5'd9;
        rif.i_issue_rd     = 5'd1;
        #1;
        check("busy3_inflight", {26'd0, rif.o_inflight}, 32'd3);
        check("busy3_ready", {31'd0, rif.o_issue_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("areset_inflight", {26'd0, rif.o_inflight}, 32'd0);
        check("areset_wb_err", {31'd0, rif.o_wb_err}, 32'd0);
        check("areset_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        check("areset_rs2_x9", rif.o_rs2_rdata, 32'd0);
        rif.i_rs1_raddr = 5'd3;
        #1;
        check("areset_rs1_x3", rif.o_rs1_rdata, 32'd0);
        tick();
        #2 rst = 1'b0;
        issue_rd(5'd1);
        #1;
        check("post_reset_ready", {31'd0, rif.o_issue_ready}, 32'd1);
        tick();
        rif.i_issue_valid = 1'b0;
        check("post_reset_inflight", {26'd0, rif.o_inflight}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file and issue scoreboard for the rv32i core. It sits directly downstream of `execute_unit`: it consumes that unit's registered write-back bus (`wvalid`/`waddr`/`wdata`), commits results into x1–x31, and supplies operands to decode. It tracks pending destination registers so decode only issues instructions whose sources are ready and whose destination has no write outstanding.

## Interface
- `XLEN`, default 32: data width.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_wb_rd_wvalid` input 1: write-back valid, from `execute_unit.o_wb_rd_wvalid`.
- `i_wb_rd_waddr` input 5: write-back destination.
- `i_wb_rd_wdata` input XLEN: write-back data.
- `i_rs1_raddr` input 5: read port 1 address.
- `i_rs2_raddr` input 5: read port 2 address.
- `o_rs1_rdata` output XLEN: read port 1 data, combinational.
- `o_rs2_rdata` output XLEN: read port 2 data, combinational.
- `i_issue_valid` input 1: decode presents an instruction.
- `i_issue_rs1_en` input 1: instruction reads rs1 (address is `i_rs1_raddr`).
- `i_issue_rs2_en` input 1: instruction reads rs2 (address is `i_rs2_raddr`).
- `i_issue_rd_en` input 1: instruction writes rd.
- `i_issue_rd` input 5: destination register.
- `o_issue_ready` output 1: no hazard; issue fires when `i_issue_valid && o_issue_ready`.
- `o_inflight` output 6: number of busy registers, 0–31.
- `o_wb_err` output 1: registered one-cycle pulse on a write-back to a non-busy register with nonzero address.

## Operation
- Storage: 31 × XLEN flops for x1–x31. x0 is not stored. Reads of x0 return 0.
- Write: on a clock edge with `i_wb_rd_wvalid` and `waddr != 0`, write `wdata` to `waddr`. Writes to x0 are dropped and raise no error.
- Scoreboard: `busy[31:1]`. `busy[0]` is constant 0.
  - Set `busy[i_issue_rd]` on an issue fire with `i_issue_rd_en` and `rd != 0`.
  - Clear `busy[waddr]` on a valid write-back with `waddr != 0`.
- Hazard: `o_issue_ready = !(rs1_en & busy_eff[rs1]) & !(rs2_en & busy_eff[rs2]) & !(rd_en & busy_eff[rd])`.
  - RAW and WAW both stall. Only one write is ever outstanding per register.
  - `busy_eff` is defined under Configuration.
- Simultaneous set and clear on the same register cannot occur while `busy_eff` includes that register. If it does occur (bypass build), set wins and the register stays busy.
- `o_inflight` is a registered counter, updated each cycle by +1 (set only), −1 (clear only) or 0 (both or neither). It must always equal popcount(`busy`).
- `o_wb_err` asserts when a write-back arrives for `waddr != 0` with `busy[waddr] == 0`. The data is still written.
- Reset (asynchronous, any time, including mid-stream): all registers ← 0, `busy` ← 0, `o_inflight` ← 0, `o_wb_err` ← 0. `o_issue_ready` is then 1 for any request. `o_rsN_rdata` reads 0.

## Timing
- Read latency 0 (combinational from address and array).
- Write and busy-clear take effect at the edge where `wvalid` is sampled.
- Busy-set takes effect at the issue-fire edge. A dependent instruction sees the hazard in the next cycle.
- `o_issue_ready` is combinational from the issue inputs, `busy`, and (bypass build) the write-back inputs.
- Decode holds `i_issue_*` stable while `i_issue_valid && !o_issue_ready`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - `busy_eff = busy & ~wb_clear_vec`.
  - A read whose address matches a valid nonzero write-back returns `i_wb_rd_wdata` in the same cycle.
  - A dependent instruction issues in the write-back cycle.
- `REGFILE_BYPASS_EN` undefined:
  - `busy_eff = busy`.
  - Reads return array contents only.
  - A dependent instruction issues one cycle after the write-back edge (one extra stall cycle).

## Test plan
- Reset then read: read x5 and x0 → both 0. `o_issue_ready = 1`, `o_inflight = 0`.
- Write x0: write-back `waddr = 0`, `wdata = 0xDEADBEEF` → x0 still reads 0, `o_wb_err = 0`, `o_inflight` unchanged.
- RAW stall:
  - Issue rd = x3 (fires), then present rs1 = x3 → `o_issue_ready = 0`, `o_inflight = 1`.
  - Write-back x3 = 0x12345678.
  - Bypass build: ready = 1 and `o_rs1_rdata = 0x12345678` in the write-back cycle.
  - Non-bypass build: ready = 1 the following cycle.
- WAW stall: issue rd = x7, then rd = x7 again → second issue held until x7 is written back; `o_inflight` goes 1 → 0 → 1.
- Spurious write-back: write-back x9 with x9 not busy → `o_wb_err` pulses one cycle and x9 takes the new data.
- Async reset mid-stream: busy x1, x2, x4 with `o_inflight = 3`, assert `rst` between edges → all outputs 0 and `o_issue_ready = 1` immediately. After release, a rd = x1 issue fires.
